// File: rtl/fir_decimator.sv
// fir_decimator: integrate-and-dump decimator (D = 2**LOG2D) feeding a small
// show-ahead result FIFO with a ready/valid output and a sticky overflow flag.
// Optional build macro DEC_ROUND_EN: when defined, each group sum is rounded
// half up before the arithmetic shift; when undefined the shift truncates
// toward minus infinity.
module fir_decimator #(
    parameter int DW    = 16,
    parameter int LOG2D = 2,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [LW-1:0] level,
    output logic          overflow
);

    localparam int AW = DW + LOG2D;        // accumulator holds D full-scale samples
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DEC_ROUND_EN
    localparam logic signed [AW:0] RND = (AW + 1)'(1) <<< (LOG2D - 1);
`endif

    // integrate state
    logic        [LOG2D-1:0] ph;
    logic signed [AW-1:0]    acc;
    logic signed [DW-1:0]    din_s;
    logic signed [AW-1:0]    sum;
    logic signed [AW:0]      sum_r;        // guard bit keeps the rounding add exact
    logic        [DW-1:0]    result;
    logic                    dump;

    // result FIFO state
    logic [DEPTH-1:0][DW-1:0] mem;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [LW-1:0]            count;
    logic                     full;
    logic                     pop;
    logic                     do_write;
    logic                     drop;

    assign din_s = din;
    // last sample of a group is the one arriving while the phase counter is all-ones
    assign dump  = din_valid && (&ph);

    // group sum including the current sample, then scale down by D
    always_comb begin
        sum   = acc + AW'(din_s);
        sum_r = (AW + 1)'(sum);
`ifdef DEC_ROUND_EN
        sum_r = sum_r + RND;
`endif
        result = DW'(sum_r >>> LOG2D);
    end

    // phase counter and accumulator; idle cycles leave both untouched
    always_ff @(posedge clk) begin
        if (!rst) begin
            ph  <= '0;
            acc <= '0;
        end else if (din_valid) begin
            if (dump) begin
                ph  <= '0;
                acc <= '0;
            end else begin
                ph  <= ph + 1'b1;
                acc <= sum;
            end
        end
    end

    assign full       = (count == LW'(DEPTH));
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    // a simultaneous pop frees the slot, so a full FIFO can still accept
    assign do_write   = dump && (!full || pop);
    assign drop       = dump && full && !pop;

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign level = count;

endmodule
